// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout and architectural constants.
// Used by the ID/EX register and later pipeline-register generations.
package pipe_pkg;

    localparam int CTRL_W       = 9;
    localparam int ZERO_REG_DEF = 31;

    localparam int CTRL_REG2LOC  = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEM2REG  = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    typedef struct packed {
        logic       reg2loc;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem2reg;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: EX holds a load whose destination a valid ID instruction reads.
// Purely combinational; XZR destinations never hazard.
module load_use_detect #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                  id_valid,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_wr_reg,
    input  logic [REG_ADDR_W-1:0] rd_reg_a,
    input  logic [REG_ADDR_W-1:0] rd_reg_b,
    input  logic                  uses_b,
    output logic                  hazard
);

    logic match_a;
    logic match_b;
    logic dst_real;

    assign dst_real = (ex_wr_reg != REG_ADDR_W'(ZERO_REG));
    assign match_a  = (ex_wr_reg == rd_reg_a);
    assign match_b  = uses_b && (ex_wr_reg == rd_reg_b);
    assign hazard   = id_valid && ex_valid && ex_mem_read && dst_real && (match_a || match_b);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid tracking, load-use bubble insertion and deferred flush.
// Latency: one cycle input to output; stall_in holds every field, flush arriving under stall is remembered.
// Backpressure: hazard_stall_out freezes PC and IF/ID while a load-use bubble is inserted.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int IMM_IN_W   = 32,
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUCTL_W   = 11,
    parameter int ZERO_REG   = ZERO_REG_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  id_valid_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    input  logic [DATA_W-1:0]     reg_a_in,
    input  logic [DATA_W-1:0]     reg_b_in,
    input  logic [IMM_IN_W-1:0]   imm_in,
    input  logic [PC_W-1:0]       pc_in,
    input  logic [ALUCTL_W-1:0]   alu_ctl_in,
    input  logic [REG_ADDR_W-1:0] wr_reg_in,
    input  logic [REG_ADDR_W-1:0] rd_reg_a_in,
    input  logic [REG_ADDR_W-1:0] rd_reg_b_in,
    input  logic                  uses_b_in,
    output logic                  ex_valid_out,
    output logic [CTRL_W-1:0]     ctrl_out,
    output logic [DATA_W-1:0]     reg_a_out,
    output logic [DATA_W-1:0]     reg_b_out,
    output logic [DATA_W-1:0]     imm_out,
    output logic [PC_W-1:0]       pc_out,
    output logic [ALUCTL_W-1:0]   alu_ctl_out,
    output logic [REG_ADDR_W-1:0] wr_reg_out,
    output logic [REG_ADDR_W-1:0] rd_reg_a_out,
    output logic [REG_ADDR_W-1:0] rd_reg_b_out,
    output logic                  hazard_stall_out,
    output logic [CNT_W-1:0]      bubble_cnt_out
);

    ctrl_t             ctrl_q;
    logic              flush_pend;
    logic              flush_eff;
    logic              hazard;
    logic              bubble;
    logic [DATA_W-1:0] imm_sext;

    assign ctrl_out  = ctrl_q;
    assign flush_eff = flush_in || flush_pend;
    assign bubble    = flush_eff || hazard;
    assign imm_sext  = {{(DATA_W-IMM_IN_W){imm_in[IMM_IN_W-1]}}, imm_in};

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG)
    ) u_load_use (
        .id_valid    (id_valid_in),
        .ex_valid    (ex_valid_out),
        .ex_mem_read (ctrl_out[CTRL_MEMREAD]),
        .ex_wr_reg   (wr_reg_out),
        .rd_reg_a    (rd_reg_a_in),
        .rd_reg_b    (rd_reg_b_in),
        .uses_b      (uses_b_in),
        .hazard      (hazard)
    );

    // Under stall the front end is already frozen, and a flush discards the ID instruction anyway.
    assign hazard_stall_out = hazard && !stall_in && !flush_eff;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_valid_out   <= 1'b0;
            ctrl_q         <= '0;
            reg_a_out      <= '0;
            reg_b_out      <= '0;
            imm_out        <= '0;
            pc_out         <= '0;
            alu_ctl_out    <= '0;
            wr_reg_out     <= '0;
            rd_reg_a_out   <= '0;
            rd_reg_b_out   <= '0;
            flush_pend     <= 1'b0;
            bubble_cnt_out <= '0;
        end else if (stall_in) begin
            if (flush_in) begin
                flush_pend <= 1'b1;
            end
        end else begin
            reg_a_out    <= reg_a_in;
            reg_b_out    <= reg_b_in;
            imm_out      <= imm_sext;
            pc_out       <= pc_in;
            alu_ctl_out  <= alu_ctl_in;
            wr_reg_out   <= wr_reg_in;
            rd_reg_a_out <= rd_reg_a_in;
            rd_reg_b_out <= rd_reg_b_in;
            flush_pend   <= 1'b0;
            if (bubble) begin
                ex_valid_out <= 1'b0;
                ctrl_q       <= '0;
                if (id_valid_in && (bubble_cnt_out != {CNT_W{1'b1}})) begin
                    bubble_cnt_out <= bubble_cnt_out + 1'b1;
                end
            end else begin
                ex_valid_out <= id_valid_in;
                ctrl_q       <= id_valid_in ? ctrl_t'(ctrl_in) : ctrl_t'('0);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table driven through a scoreboard queue, plus reset and
// counter-saturation sequences on a second instance with a 2-bit counter.
module tb_id_ex_pipe_reg;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        stall_in, flush_in, id_valid_in, uses_b_in;
    logic [8:0]  ctrl_in;
    logic [63:0] reg_a_in, reg_b_in;
    logic [31:0] imm_in, pc_in;
    logic [10:0] alu_ctl_in;
    logic [4:0]  wr_reg_in, rd_reg_a_in, rd_reg_b_in;

    logic        ex_valid_out, hazard_stall_out;
    logic [8:0]  ctrl_out;
    logic [63:0] reg_a_out, reg_b_out, imm_out;
    logic [31:0] pc_out;
    logic [10:0] alu_ctl_out;
    logic [4:0]  wr_reg_out, rd_reg_a_out, rd_reg_b_out;
    logic [15:0] bubble_cnt_out;

    logic        s_ex_valid, s_hazard;
    logic [8:0]  s_ctrl;
    logic [63:0] s_reg_a, s_reg_b, s_imm;
    logic [31:0] s_pc;
    logic [10:0] s_alu;
    logic [4:0]  s_wr, s_ra, s_rb;
    logic [1:0]  s_cnt;

    always #5 CLK = ~CLK;

    id_ex_pipe_reg dut (
        .CLK(CLK), .RESET(RESET), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid_in(id_valid_in), .ctrl_in(ctrl_in), .reg_a_in(reg_a_in), .reg_b_in(reg_b_in),
        .imm_in(imm_in), .pc_in(pc_in), .alu_ctl_in(alu_ctl_in), .wr_reg_in(wr_reg_in),
        .rd_reg_a_in(rd_reg_a_in), .rd_reg_b_in(rd_reg_b_in), .uses_b_in(uses_b_in),
        .ex_valid_out(ex_valid_out), .ctrl_out(ctrl_out), .reg_a_out(reg_a_out),
        .reg_b_out(reg_b_out), .imm_out(imm_out), .pc_out(pc_out), .alu_ctl_out(alu_ctl_out),
        .wr_reg_out(wr_reg_out), .rd_reg_a_out(rd_reg_a_out), .rd_reg_b_out(rd_reg_b_out),
        .hazard_stall_out(hazard_stall_out), .bubble_cnt_out(bubble_cnt_out)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid_in(id_valid_in), .ctrl_in(ctrl_in), .reg_a_in(reg_a_in), .reg_b_in(reg_b_in),
        .imm_in(imm_in), .pc_in(pc_in), .alu_ctl_in(alu_ctl_in), .wr_reg_in(wr_reg_in),
        .rd_reg_a_in(rd_reg_a_in), .rd_reg_b_in(rd_reg_b_in), .uses_b_in(uses_b_in),
        .ex_valid_out(s_ex_valid), .ctrl_out(s_ctrl), .reg_a_out(s_reg_a),
        .reg_b_out(s_reg_b), .imm_out(s_imm), .pc_out(s_pc), .alu_ctl_out(s_alu),
        .wr_reg_out(s_wr), .rd_reg_a_out(s_ra), .rd_reg_b_out(s_rb),
        .hazard_stall_out(s_hazard), .bubble_cnt_out(s_cnt)
    );

    typedef struct {
        logic        stall, flush, idv;
        logic [8:0]  ctrl;
        logic [31:0] pc;
        logic [4:0]  wr, ra, rb;
        logic        usesb;
        logic        e_haz, e_valid;
        logic [8:0]  e_ctrl;
        int          e_cnt;
        logic        chk_dp;
    } vec_t;

    typedef struct {
        int          idx;
        logic        valid;
        logic [8:0]  ctrl;
        logic        chk_dp;
        logic [31:0] pc;
        logic [4:0]  wr, ra, rb;
        logic [63:0] ra_d, rb_d, imm;
        logic [10:0] alu;
        int          cnt;
    } exp_t;

    localparam logic [8:0] LDUR = 9'h0D8;
    localparam logic [8:0] ADD  = 9'h010;

    int   tests = 0;
    int   failed = 0;
    exp_t sb[$];
    exp_t last_e;
    vec_t vt[27];
    logic [31:0] imm_in_tab[4];
    logic [63:0] imm_exp_tab[4];

    function automatic vec_t mk(logic st, logic fl, logic idv, logic [8:0] c, logic [31:0] pc,
                                logic [4:0] wr, logic [4:0] ra, logic [4:0] rb, logic ub,
                                logic eh, logic ev, logic [8:0] ec, int cnt, logic dp);
        vec_t v;
        v.stall = st; v.flush = fl; v.idv = idv; v.ctrl = c; v.pc = pc;
        v.wr = wr; v.ra = ra; v.rb = rb; v.usesb = ub;
        v.e_haz = eh; v.e_valid = ev; v.e_ctrl = ec; v.e_cnt = cnt; v.chk_dp = dp;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int sat3(int c);
        return (c > 3) ? 3 : c;
    endfunction

    task automatic check_out(exp_t e);
        string t;
        t = $sformatf("v%0d", e.idx);
        chk({t, " ex_valid"}, 64'(ex_valid_out), 64'(e.valid));
        chk({t, " ctrl"}, 64'(ctrl_out), 64'(e.ctrl));
        chk({t, " bubble_cnt"}, 64'(bubble_cnt_out), 64'(e.cnt));
        chk({t, " bubble_cnt_sat"}, 64'(s_cnt), 64'(sat3(e.cnt)));
        if (e.chk_dp) begin
            chk({t, " pc"}, 64'(pc_out), 64'(e.pc));
            chk({t, " imm"}, imm_out, e.imm);
            chk({t, " reg_a"}, reg_a_out, e.ra_d);
            chk({t, " reg_b"}, reg_b_out, e.rb_d);
            chk({t, " alu_ctl"}, 64'(alu_ctl_out), 64'(e.alu));
            chk({t, " wr_reg"}, 64'(wr_reg_out), 64'(e.wr));
            chk({t, " rd_reg_a"}, 64'(rd_reg_a_out), 64'(e.ra));
            chk({t, " rd_reg_b"}, 64'(rd_reg_b_out), 64'(e.rb));
        end
    endtask

    task automatic apply(int i, vec_t v);
        exp_t e;
        stall_in    = v.stall;
        flush_in    = v.flush;
        id_valid_in = v.idv;
        ctrl_in     = v.ctrl;
        pc_in       = v.pc;
        wr_reg_in   = v.wr;
        rd_reg_a_in = v.ra;
        rd_reg_b_in = v.rb;
        uses_b_in   = v.usesb;
        reg_a_in    = {32'hA5A5_0000, v.pc};
        reg_b_in    = {v.pc, 32'h5A5A_0001};
        alu_ctl_in  = v.pc[10:0] ^ 11'h5C3;
        imm_in      = imm_in_tab[i % 4];
        #1;
        chk($sformatf("v%0d hazard_stall", i), 64'(hazard_stall_out), 64'(v.e_haz));
        if (v.stall) begin
            e = last_e;
        end else begin
            e.pc = v.pc; e.wr = v.wr; e.ra = v.ra; e.rb = v.rb;
            e.ra_d = reg_a_in; e.rb_d = reg_b_in; e.alu = alu_ctl_in;
            e.imm = imm_exp_tab[i % 4];
            e.chk_dp = v.chk_dp;
            last_e = e;
        end
        e.idx = i; e.valid = v.e_valid; e.ctrl = v.e_ctrl; e.cnt = v.e_cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            tests++; failed++;
            $display("FAIL v%0d scoreboard empty", i);
        end else begin
            check_out(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        imm_in_tab[0] = 32'hFFFF_FFF0; imm_exp_tab[0] = 64'hFFFF_FFFF_FFFF_FFF0;
        imm_in_tab[1] = 32'h0000_0008; imm_exp_tab[1] = 64'h0000_0000_0000_0008;
        imm_in_tab[2] = 32'h8000_0000; imm_exp_tab[2] = 64'hFFFF_FFFF_8000_0000;
        imm_in_tab[3] = 32'h7FFF_FFFF; imm_exp_tab[3] = 64'h0000_0000_7FFF_FFFF;

        //            st fl iv ctrl    pc     wr ra rb ub  haz val e_ctrl cnt dp
        vt[0]  = mk(0, 0, 1, 9'h1A5, 32'h40, 5, 1, 2, 1,  0, 1, 9'h1A5, 0, 1);
        vt[1]  = mk(0, 0, 1, LDUR,   32'h44, 3, 1, 0, 0,  0, 1, LDUR,   0, 1);
        vt[2]  = mk(0, 0, 1, ADD,    32'h48, 4, 3, 2, 1,  1, 0, 9'h000, 1, 0);
        vt[3]  = mk(0, 0, 1, ADD,    32'h48, 4, 3, 2, 1,  0, 1, ADD,    1, 1);
        vt[4]  = mk(0, 0, 1, LDUR,   32'h4C, 31, 1, 0, 0, 0, 1, LDUR,   1, 1);
        vt[5]  = mk(0, 0, 1, ADD,    32'h50, 4, 31, 31, 1, 0, 1, ADD,   1, 1);
        vt[6]  = mk(0, 0, 1, LDUR,   32'h54, 7, 1, 0, 0,  0, 1, LDUR,   1, 1);
        vt[7]  = mk(0, 0, 1, ADD,    32'h58, 4, 2, 7, 0,  0, 1, ADD,    1, 1);
        vt[8]  = mk(0, 0, 1, LDUR,   32'h5C, 7, 1, 0, 0,  0, 1, LDUR,   1, 1);
        vt[9]  = mk(0, 0, 1, ADD,    32'h60, 4, 2, 7, 1,  1, 0, 9'h000, 2, 0);
        vt[10] = mk(0, 0, 1, ADD,    32'h60, 4, 2, 7, 1,  0, 1, ADD,    2, 1);
        vt[11] = mk(0, 0, 1, LDUR,   32'h64, 9, 1, 0, 0,  0, 1, LDUR,   2, 1);
        vt[12] = mk(0, 0, 0, ADD,    32'h68, 4, 9, 0, 0,  0, 0, 9'h000, 2, 1);
        vt[13] = mk(0, 1, 1, ADD,    32'h6C, 4, 1, 0, 0,  0, 0, 9'h000, 3, 0);
        vt[14] = mk(0, 1, 0, ADD,    32'h6C, 4, 1, 0, 0,  0, 0, 9'h000, 3, 0);
        vt[15] = mk(0, 0, 1, LDUR,   32'h70, 3, 1, 0, 0,  0, 1, LDUR,   3, 1);
        vt[16] = mk(1, 1, 1, 9'h1A5, 32'h74, 4, 3, 0, 0,  0, 1, LDUR,   3, 1);
        vt[17] = mk(1, 0, 1, 9'h1A5, 32'h74, 4, 3, 0, 0,  0, 1, LDUR,   3, 1);
        vt[18] = mk(1, 0, 1, 9'h1A5, 32'h74, 4, 3, 0, 0,  0, 1, LDUR,   3, 1);
        vt[19] = mk(0, 0, 1, ADD,    32'h78, 4, 3, 0, 0,  0, 0, 9'h000, 4, 0);
        vt[20] = mk(0, 0, 1, ADD,    32'h7C, 4, 3, 0, 0,  0, 1, ADD,    4, 1);
        vt[21] = mk(1, 1, 1, ADD,    32'h80, 4, 1, 0, 0,  0, 1, ADD,    4, 1);
        vt[22] = mk(1, 1, 1, ADD,    32'h84, 4, 1, 0, 0,  0, 1, ADD,    4, 1);
        vt[23] = mk(0, 0, 1, ADD,    32'h88, 4, 1, 0, 0,  0, 0, 9'h000, 5, 0);
        vt[24] = mk(0, 0, 1, ADD,    32'h8C, 4, 1, 0, 0,  0, 1, ADD,    5, 1);
        vt[25] = mk(0, 0, 1, LDUR,   32'h90, 5, 1, 0, 0,  0, 1, LDUR,   5, 1);
        vt[26] = mk(0, 1, 1, ADD,    32'h94, 4, 5, 0, 0,  0, 0, 9'h000, 6, 0);

        // Reset with every input high, including stall and flush.
        RESET = 1'b1; stall_in = 1'b1; flush_in = 1'b1; id_valid_in = 1'b1; uses_b_in = 1'b1;
        ctrl_in = '1; reg_a_in = '1; reg_b_in = '1; imm_in = '1; pc_in = '1;
        alu_ctl_in = '1; wr_reg_in = '1; rd_reg_a_in = '1; rd_reg_b_in = '1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst ex_valid", 64'(ex_valid_out), 64'd0);
        chk("rst ctrl", 64'(ctrl_out), 64'd0);
        chk("rst reg_a", reg_a_out, 64'd0);
        chk("rst reg_b", reg_b_out, 64'd0);
        chk("rst imm", imm_out, 64'd0);
        chk("rst pc", 64'(pc_out), 64'd0);
        chk("rst alu_ctl", 64'(alu_ctl_out), 64'd0);
        chk("rst wr_reg", 64'(wr_reg_out), 64'd0);
        chk("rst rd_reg_a", 64'(rd_reg_a_out), 64'd0);
        chk("rst rd_reg_b", 64'(rd_reg_b_out), 64'd0);
        chk("rst hazard_stall", 64'(hazard_stall_out), 64'd0);
        chk("rst bubble_cnt", 64'(bubble_cnt_out), 64'd0);
        RESET = 1'b0;

        for (int i = 0; i < 27; i++) begin
            apply(i, vt[i]);
        end

        // Counter saturation on the 2-bit instance: five consecutive flush bubbles.
        RESET = 1'b1; stall_in = 1'b0; flush_in = 1'b0; id_valid_in = 1'b0;
        @(posedge CLK); #1;
        chk("sat rst cnt", 64'(s_cnt), 64'd0);
        RESET = 1'b0;
        flush_in = 1'b1; id_valid_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK); #1;
            chk($sformatf("sat flush%0d cnt16", k), 64'(bubble_cnt_out), 64'(k));
            chk($sformatf("sat flush%0d cnt2", k), 64'(s_cnt), 64'(sat3(k)));
            chk($sformatf("sat flush%0d valid", k), 64'(s_ex_valid), 64'd0);
        end
        flush_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
